// File: rtl/raccoon_pkg.sv
// Shared definitions for the raccoon game: direction indices, move FSM encoding,
// default timing constants (25 MHz core clock) and a one-hot helper.
// Used by move_request_gen, switch_debounce and the raccoon position controller.
package raccoon_pkg;

    // Bit positions within a {Rt,Lt,Dn,Up} direction vector
    localparam int DIR_UP   = 0;
    localparam int DIR_DN   = 1;
    localparam int DIR_LT   = 2;
    localparam int DIR_RT   = 3;
    localparam int NUM_DIRS = 4;

    // Default timing at 25 MHz
    localparam int DEFAULT_DEBOUNCE_LIMIT = 250000;    // 10 ms
    localparam int DEFAULT_REPEAT_DELAY   = 12500000;  // 500 ms to first repeat
    localparam int DEFAULT_REPEAT_PERIOD  = 2550000;   // ~102 ms between repeats
    localparam int DEFAULT_CNT_WIDTH      = 24;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } move_state_t;

    // True when exactly one direction bit is set
    function automatic logic is_one_hot(input logic [NUM_DIRS-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/switch_debounce.sv
// Purpose: 2-FF synchroniser plus counter debouncer for one raw switch.
// Latency: a level sampled at edge t is accepted on o_Level at edge t+2+c_LIMIT.
// Ports: i_Clk, i_Rst_n (async active-low), i_Switch (raw async), o_Level (debounced).
module switch_debounce #(
    parameter int c_LIMIT = 250000,
    parameter int c_WIDTH = 24
) (
    input  logic i_Clk,
    input  logic i_Rst_n,
    input  logic i_Switch,
    output logic o_Level
);

    localparam logic [c_WIDTH-1:0] LIMIT_C = c_WIDTH'(c_LIMIT);

    logic               sync_q1;
    logic               sync_q2;
    logic               stable_q;
    logic [c_WIDTH-1:0] cnt_q;

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= i_Switch;
            sync_q2 <= sync_q1;
        end
    end

    // The counter only runs while the synced level disagrees with the accepted
    // one; any bounce back to the accepted level restarts the hold window.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else if (sync_q2 == stable_q) begin
            cnt_q    <= '0;
        end else if (cnt_q == LIMIT_C) begin
            stable_q <= sync_q2;
            cnt_q    <= '0;
        end else begin
            cnt_q    <= cnt_q + 1'b1;
        end
    end

    assign o_Level = stable_q;

endmodule

// File: rtl/move_request_gen.sv
// Purpose: turns four raw direction switches into mutually exclusive one-cycle
//   move pulses: one on press, then auto-repeat while a single direction is held.
// Ports: i_Clk, i_Rst_n (async active-low), i_Switch_{Up,Dn,Lt,Rt} raw levels,
//   i_Enable gate, o_Dir_Held debounced {Rt,Lt,Dn,Up}, o_Move_* registered pulses.
module move_request_gen
    import raccoon_pkg::*;
#(
    parameter int c_DEBOUNCE_LIMIT = DEFAULT_DEBOUNCE_LIMIT,
    parameter int c_REPEAT_DELAY   = DEFAULT_REPEAT_DELAY,
    parameter int c_REPEAT_PERIOD  = DEFAULT_REPEAT_PERIOD,
    parameter int c_CNT_WIDTH      = DEFAULT_CNT_WIDTH
) (
    input  logic       i_Clk,
    input  logic       i_Rst_n,
    input  logic       i_Switch_Up,
    input  logic       i_Switch_Dn,
    input  logic       i_Switch_Lt,
    input  logic       i_Switch_Rt,
    input  logic       i_Enable,
    output logic [3:0] o_Dir_Held,
    output logic       o_Move_Up,
    output logic       o_Move_Dn,
    output logic       o_Move_Lt,
    output logic       o_Move_Rt
);

    localparam logic [c_CNT_WIDTH-1:0] DELAY_LAST  = c_CNT_WIDTH'(c_REPEAT_DELAY - 1);
    localparam logic [c_CNT_WIDTH-1:0] PERIOD_LAST = c_CNT_WIDTH'(c_REPEAT_PERIOD - 1);

    logic [NUM_DIRS-1:0] raw_sw;
    logic [NUM_DIRS-1:0] held;

    assign raw_sw[DIR_UP] = i_Switch_Up;
    assign raw_sw[DIR_DN] = i_Switch_Dn;
    assign raw_sw[DIR_LT] = i_Switch_Lt;
    assign raw_sw[DIR_RT] = i_Switch_Rt;

    for (genvar g = 0; g < NUM_DIRS; g++) begin : g_deb
        switch_debounce #(
            .c_LIMIT (c_DEBOUNCE_LIMIT),
            .c_WIDTH (c_CNT_WIDTH)
        ) u_deb (
            .i_Clk    (i_Clk),
            .i_Rst_n  (i_Rst_n),
            .i_Switch (raw_sw[g]),
            .o_Level  (held[g])
        );
    end

    move_state_t             state_q, state_d;
    logic [NUM_DIRS-1:0]     latch_q, latch_d;
    logic [c_CNT_WIDTH-1:0]  cnt_q,   cnt_d;
    logic [NUM_DIRS-1:0]     move_q,  move_d;
    logic                    dir_valid;
    logic                    hold_broken;

    // Chords and empty inputs are not a direction
    assign dir_valid   = is_one_hot(held);
    // Any change of the held pattern (release, chord, redirect) or disable ends
    // the press; a redirect is then picked up fresh from IDLE.
    assign hold_broken = (held != latch_q) || !i_Enable;

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q <= ST_IDLE;
            latch_q <= '0;
            cnt_q   <= '0;
            move_q  <= '0;
        end else begin
            state_q <= state_d;
            latch_q <= latch_d;
            cnt_q   <= cnt_d;
            move_q  <= move_d;
        end
    end

    always_comb begin
        state_d = state_q;
        latch_d = latch_q;
        cnt_d   = cnt_q;
        move_d  = '0;
        case (state_q)
            ST_IDLE: begin
                if (dir_valid && i_Enable) begin
                    move_d  = held;
                    latch_d = held;
                    cnt_d   = '0;
                    state_d = ST_DELAY;
                end
            end
            ST_DELAY: begin
                if (hold_broken) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == DELAY_LAST) begin
                    move_d  = latch_q;
                    cnt_d   = '0;
                    state_d = ST_REPEAT;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            ST_REPEAT: begin
                if (hold_broken) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == PERIOD_LAST) begin
                    move_d  = latch_q;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign o_Dir_Held = held;
    assign o_Move_Up  = move_q[DIR_UP];
    assign o_Move_Dn  = move_q[DIR_DN];
    assign o_Move_Lt  = move_q[DIR_LT];
    assign o_Move_Rt  = move_q[DIR_RT];

endmodule

// File: tb/tb_move_request_gen.sv
// Directed bench for move_request_gen with debounce 4, delay 10, period 5.
// Cycle k of a scenario means: inputs are set just before active edge k and
// outputs are sampled 1 time unit after edge k.
module tb_move_request_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sw_up = 1'b0;
    logic       sw_dn = 1'b0;
    logic       sw_lt = 1'b0;
    logic       sw_rt = 1'b0;
    logic       en = 1'b1;
    logic [3:0] dir_held;
    logic       mv_up, mv_dn, mv_lt, mv_rt;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    move_request_gen #(
        .c_DEBOUNCE_LIMIT (4),
        .c_REPEAT_DELAY   (10),
        .c_REPEAT_PERIOD  (5),
        .c_CNT_WIDTH      (8)
    ) dut (
        .i_Clk       (clk),
        .i_Rst_n     (rst_n),
        .i_Switch_Up (sw_up),
        .i_Switch_Dn (sw_dn),
        .i_Switch_Lt (sw_lt),
        .i_Switch_Rt (sw_rt),
        .i_Enable    (en),
        .o_Dir_Held  (dir_held),
        .o_Move_Up   (mv_up),
        .o_Move_Dn   (mv_dn),
        .o_Move_Lt   (mv_lt),
        .o_Move_Rt   (mv_rt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Holds reset over a few edges with all switches low, then releases it
    // mid-cycle so that the next edge is edge 0 of the scenario.
    task automatic apply_reset(input logic en_v);
        rst_n = 1'b0;
        sw_up = 1'b0; sw_dn = 1'b0; sw_lt = 1'b0; sw_rt = 1'b0;
        en    = en_v;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = -1;
    endtask

    task automatic test_reset();
        logic [7:0] got;
        rst_n = 1'b1;
        #2;
        sw_up = 1'b1;
        rst_n = 1'b0;
        #1;
        got = {dir_held, mv_rt, mv_lt, mv_dn, mv_up};
        total++;
        if (got !== 8'h00) begin
            bad++;
            $display("FAIL reset_async got=%b exp=%b", got, 8'h00);
        end
        // Switch held high while in reset must not leak through
        repeat (8) @(posedge clk);
        #1;
        got = {dir_held, mv_rt, mv_lt, mv_dn, mv_up};
        total++;
        if (got !== 8'h00) begin
            bad++;
            $display("FAIL reset_hold got=%b exp=%b", got, 8'h00);
        end
    endtask

    task automatic test_press_repeat();
        logic [3:0] exp_h, exp_m;
        logic [7:0] got;
        apply_reset(1'b1);
        for (int k = 0; k < 30; k++) begin
            sw_up = 1'b1;
            tick();
            exp_h = (k >= 6) ? 4'b0001 : 4'b0000;
            exp_m = (k == 7 || k == 17 || k == 22 || k == 27) ? 4'b0001 : 4'b0000;
            got   = {dir_held, mv_rt, mv_lt, mv_dn, mv_up};
            total++;
            if (got !== {exp_h, exp_m}) begin
                bad++;
                $display("FAIL press_repeat cyc=%0d got=%b exp=%b", cyc, got, {exp_h, exp_m});
            end
        end
    endtask

    task automatic test_bounce();
        logic [7:0] got;
        apply_reset(1'b1);
        for (int k = 0; k < 30; k++) begin
            sw_up = (k < 20) ? ((k / 2) % 2 == 0) : 1'b0;
            tick();
            got = {dir_held, mv_rt, mv_lt, mv_dn, mv_up};
            total++;
            if (got !== 8'h00) begin
                bad++;
                $display("FAIL bounce cyc=%0d got=%b exp=%b", cyc, got, 8'h00);
            end
        end
    endtask

    task automatic test_chord();
        logic [3:0] exp_h, exp_m;
        logic [7:0] got;
        apply_reset(1'b1);
        for (int k = 0; k < 46; k++) begin
            sw_up = 1'b1;
            sw_lt = (k < 30);
            tick();
            exp_h = (k < 6) ? 4'b0000 : (k < 36) ? 4'b0101 : 4'b0001;
            exp_m = (k == 37) ? 4'b0001 : 4'b0000;
            got   = {dir_held, mv_rt, mv_lt, mv_dn, mv_up};
            total++;
            if (got !== {exp_h, exp_m}) begin
                bad++;
                $display("FAIL chord cyc=%0d got=%b exp=%b", cyc, got, {exp_h, exp_m});
            end
        end
    endtask

    task automatic test_redirect();
        logic [3:0] exp_h, exp_m;
        logic [7:0] got;
        apply_reset(1'b1);
        for (int k = 0; k < 62; k++) begin
            sw_up = (k < 40);
            sw_rt = (k >= 40);
            tick();
            exp_h = (k < 6) ? 4'b0000 : (k < 46) ? 4'b0001 : 4'b1000;
            if (k == 7 || k == 17 || k == 22 || k == 27 || k == 32 || k == 37 || k == 42)
                exp_m = 4'b0001;
            else if (k == 48 || k == 58)
                exp_m = 4'b1000;
            else
                exp_m = 4'b0000;
            got = {dir_held, mv_rt, mv_lt, mv_dn, mv_up};
            total++;
            if (got !== {exp_h, exp_m}) begin
                bad++;
                $display("FAIL redirect cyc=%0d got=%b exp=%b", cyc, got, {exp_h, exp_m});
            end
        end
    endtask

    // Enable is high during cycle 50 (first sampled at edge 51) and drops
    // before edge 63, which must suppress the repeat due at 66.
    task automatic test_enable();
        logic [3:0] exp_h, exp_m;
        logic [7:0] got;
        apply_reset(1'b0);
        for (int k = 0; k < 70; k++) begin
            sw_up = 1'b1;
            en    = (k >= 51 && k < 63);
            tick();
            exp_h = (k >= 6) ? 4'b0001 : 4'b0000;
            exp_m = (k == 51 || k == 61) ? 4'b0001 : 4'b0000;
            got   = {dir_held, mv_rt, mv_lt, mv_dn, mv_up};
            total++;
            if (got !== {exp_h, exp_m}) begin
                bad++;
                $display("FAIL enable cyc=%0d got=%b exp=%b", cyc, got, {exp_h, exp_m});
            end
        end
    endtask

    task automatic test_reset_during_hold();
        logic [3:0] exp_h, exp_m;
        logic [7:0] got;
        apply_reset(1'b1);
        for (int k = 0; k < 26; k++) begin
            sw_up = 1'b1;
            tick();
            exp_h = (k >= 6) ? 4'b0001 : 4'b0000;
            exp_m = (k == 7 || k == 17 || k == 22) ? 4'b0001 : 4'b0000;
            got   = {dir_held, mv_rt, mv_lt, mv_dn, mv_up};
            total++;
            if (got !== {exp_h, exp_m}) begin
                bad++;
                $display("FAIL rst_hold_pre cyc=%0d got=%b exp=%b", cyc, got, {exp_h, exp_m});
            end
        end
        // Mid-REPEAT asynchronous reset, Up still held
        #2;
        rst_n = 1'b0;
        #1;
        got = {dir_held, mv_rt, mv_lt, mv_dn, mv_up};
        total++;
        if (got !== 8'h00) begin
            bad++;
            $display("FAIL rst_hold_async got=%b exp=%b", got, 8'h00);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = -1;
        for (int k = 0; k < 12; k++) begin
            tick();
            exp_h = (k >= 6) ? 4'b0001 : 4'b0000;
            exp_m = (k == 7) ? 4'b0001 : 4'b0000;
            got   = {dir_held, mv_rt, mv_lt, mv_dn, mv_up};
            total++;
            if (got !== {exp_h, exp_m}) begin
                bad++;
                $display("FAIL rst_hold_post cyc=%0d got=%b exp=%b", cyc, got, {exp_h, exp_m});
            end
        end
    endtask

    initial begin
        test_reset();
        test_press_repeat();
        test_bounce();
        test_chord();
        test_redirect();
        test_enable();
        test_reset_during_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
